// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared lock-state encodings and sign-magnitude helper for the 5-bit ADPLL blocks
package adpll_pkg;

   typedef enum logic [1:0] {
      LS_IDLE   = 2'b00,
      LS_ACQ    = 2'b01,
      LS_LOCKED = 2'b10
   } lock_state_t;

   // {sign, magnitude} to two's complement; a negative zero folds to 0
   function automatic logic signed [5:0] sm_to_tc(input logic sign, input logic [4:0] mag);
      logic signed [5:0] m;
      m = signed'({1'b0, mag});
      return sign ? -m : m;
   endfunction

endpackage

// File: rtl/edge_sync_det.sv
// rtl/edge_sync_det.sv - two-flop synchronizer with registered rising-edge pulse
module edge_sync_det (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   // Resynchronize the foreign clock and emit one clk-wide pulse per rising edge,
   // three clk cycles after the edge arrives
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         rise   <= 1'b0;
      end else begin
         meta   <= level;
         sync   <= meta;
         sync_d <= sync;
         rise   <= sync & ~sync_d;
      end
   end

endmodule

// File: rtl/adpll_lock_detector.sv
// rtl/adpll_lock_detector.sv - ADPLL lock monitor: filter settling plus ref/fb frequency window
module adpll_lock_detector #(
   parameter int TOL           = 1,
   parameter int LOCK_CYCLES   = 64,
   parameter int UNLOCK_CYCLES = 4,
   parameter int WIN_LOG2      = 4,
   parameter int FREQ_TOL      = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [4:0]          filter_out,
   input  logic                filter_sign,
   input  logic                clk_ref,
   input  logic                fb_clk,
   input  logic                clr_lost,
   output logic                lock,
   output logic [1:0]          lock_state,
   output logic                lost_lock,
   output logic [WIN_LOG2+1:0] freq_diff,
   output logic                freq_valid
);

   import adpll_pkg::*;

   localparam int SW = $clog2(LOCK_CYCLES + 1);
   localparam int BW = $clog2(UNLOCK_CYCLES + 1);
   localparam int FW = WIN_LOG2 + 1;
   localparam int DW = WIN_LOG2 + 2;

   localparam logic [SW-1:0]       STABLE_MAX = SW'(LOCK_CYCLES);
   localparam logic [BW-1:0]       BAD_MAX    = BW'(UNLOCK_CYCLES);
   localparam logic [WIN_LOG2-1:0] REF_LAST   = '1;
   localparam logic [FW-1:0]       FB_MAX     = '1;
   localparam logic [DW-1:0]       WIN_EDGES  = DW'(2 ** WIN_LOG2);
   localparam logic [6:0]          TOL_V      = 7'(TOL);
   localparam logic [DW-1:0]       FTOL_V     = DW'(FREQ_TOL);

   lock_state_t state;
   lock_state_t state_nxt;
   logic        loss;

   logic ref_rise;
   logic fb_rise;

   logic signed [5:0] v;
   logic signed [5:0] v_prev;
   logic              prev_valid;
   logic [6:0]        delta;
   logic [6:0]        delta_mag;
   logic              stable;

   logic [SW-1:0] stable_cnt;
   logic [BW-1:0] bad_cnt;

   logic [WIN_LOG2-1:0] ref_cnt;
   logic [FW-1:0]       fb_cnt;
   logic [FW-1:0]       fb_incl;
   logic                win_done;
   logic [DW-1:0]       diff_new;
   logic [DW-1:0]       diff_mag;
   logic                ok_fresh;
   logic                freq_ok;
   logic                freq_ok_eff;

   edge_sync_det u_ref_sync (
      .clk   (clk),
      .reset (reset),
      .level (clk_ref),
      .rise  (ref_rise)
   );

   edge_sync_det u_fb_sync (
      .clk   (clk),
      .reset (reset),
      .level (fb_clk),
      .rise  (fb_rise)
   );

   // Filter step size between consecutive samples (7 bits cannot overflow for -31..31)
   assign v         = sm_to_tc(filter_sign, filter_out);
   assign delta     = {v[5], v} - {v_prev[5], v_prev};
   assign delta_mag = delta[6] ? (~delta + 7'd1) : delta;
   assign stable    = prev_valid && (delta_mag <= TOL_V);

   // Window closure: an fb edge coinciding with the closing ref edge still counts
   assign fb_incl     = (fb_rise && (fb_cnt != FB_MAX)) ? fb_cnt + 1'b1 : fb_cnt;
   assign win_done    = en && ref_rise && (ref_cnt == REF_LAST);
   assign diff_new    = {1'b0, fb_incl} - WIN_EDGES;
   assign diff_mag    = diff_new[DW-1] ? (~diff_new + 1'b1) : diff_new;
   assign ok_fresh    = (diff_mag <= FTOL_V);
   assign freq_ok_eff = win_done ? ok_fresh : freq_ok;

   // Outputs decode straight from the state register
   assign lock       = (state == LS_LOCKED);
   assign lock_state = state;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and loss-event decode; a window closing this cycle decides with its fresh result
   always_comb begin
      state_nxt = state;
      loss      = 1'b0;
      if (!en) begin
         state_nxt = LS_IDLE;
      end else begin
         case (state)
            LS_IDLE: begin
               state_nxt = LS_ACQ;
            end
            LS_ACQ: begin
               if ((stable_cnt == STABLE_MAX) && freq_ok_eff) begin
                  state_nxt = LS_LOCKED;
               end
            end
            LS_LOCKED: begin
               if ((bad_cnt == BAD_MAX) || (win_done && !ok_fresh)) begin
                  state_nxt = LS_ACQ;
                  loss      = 1'b1;
               end
            end
            default: begin
               state_nxt = LS_IDLE;
            end
         endcase
      end
   end

   // Previous-sample register; the validity flag keeps the first sample after IDLE unstable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_prev     <= '0;
         prev_valid <= 1'b0;
      end else begin
         v_prev     <= v;
         prev_valid <= en;
      end
   end

   // Saturating runs of stable and unstable samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_cnt <= '0;
         bad_cnt    <= '0;
      end else if (!en) begin
         stable_cnt <= '0;
         bad_cnt    <= '0;
      end else begin
         if (loss || !stable) begin
            stable_cnt <= '0;
         end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + 1'b1;
         end
         if (stable) begin
            bad_cnt <= '0;
         end else if (bad_cnt != BAD_MAX) begin
            bad_cnt <= bad_cnt + 1'b1;
         end
      end
   end

   // Frequency window: count edges, publish the fb surplus when the window closes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_cnt    <= '0;
         fb_cnt     <= '0;
         freq_ok    <= 1'b0;
         freq_diff  <= '0;
         freq_valid <= 1'b0;
      end else if (!en) begin
         ref_cnt    <= '0;
         fb_cnt     <= '0;
         freq_ok    <= 1'b0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= win_done;
         if (win_done) begin
            freq_diff <= diff_new;
            freq_ok   <= ok_fresh;
            ref_cnt   <= '0;
            fb_cnt    <= '0;
         end else begin
            if (ref_rise) begin
               ref_cnt <= ref_cnt + 1'b1;
            end
            fb_cnt <= fb_incl;
         end
      end
   end

   // Sticky loss flag; a loss in the same cycle as a clear wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lost_lock <= 1'b0;
      end else if (loss) begin
         lost_lock <= 1'b1;
      end else if (clr_lost) begin
         lost_lock <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adpll_lock_detector.sv
// tb/tb_adpll_lock_detector.sv - scoreboard bench for adpll_lock_detector
module tb_adpll_lock_detector;

   localparam int TOL           = 1;
   localparam int LOCK_CYCLES   = 64;
   localparam int UNLOCK_CYCLES = 4;
   localparam int WIN_LOG2      = 4;
   localparam int FREQ_TOL      = 1;
   localparam int WIN           = 1 << WIN_LOG2;
   localparam int FB_SAT        = (1 << (WIN_LOG2 + 1)) - 1;

   logic                       clk = 1'b0;
   logic                       reset = 1'b0;
   logic                       en = 1'b0;
   logic [4:0]                 filter_out = 5'd0;
   logic                       filter_sign = 1'b0;
   logic                       clk_ref = 1'b0;
   logic                       fb_clk = 1'b0;
   logic                       clr_lost = 1'b0;
   logic                       lock;
   logic [1:0]                 lock_state;
   logic                       lost_lock;
   logic signed [WIN_LOG2+1:0] freq_diff;
   logic                       freq_valid;

   adpll_lock_detector #(
      .TOL(TOL), .LOCK_CYCLES(LOCK_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES),
      .WIN_LOG2(WIN_LOG2), .FREQ_TOL(FREQ_TOL)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .filter_out(filter_out), .filter_sign(filter_sign),
      .clk_ref(clk_ref), .fb_clk(fb_clk), .clr_lost(clr_lost), .lock(lock),
      .lock_state(lock_state), .lost_lock(lost_lock), .freq_diff(freq_diff), .freq_valid(freq_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int fv_seen = 0;
   int last_fd = 0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
      end
   endtask

   // Reference and feedback clocks, derived from clk so edge times are exact
   int ref_per = 10;
   int fb_per = 10;
   int rc = 0;
   int fc = 0;
   bit run_clk = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (run_clk) begin
            rc = (rc + 1) % ref_per;
            fc = (fc + 1) % fb_per;
            clk_ref = (rc < ref_per / 2);
            fb_clk  = (fc < fb_per / 2);
         end
      end
   end

   // Reference model: expected outputs after every clk edge
   typedef struct packed {
      logic [1:0] ls;
      logic       lk;
      logic       lost;
      logic       fv;
   } exp_t;

   exp_t exp_q[$];
   int   fd_q[$];

   int m_state = 0, m_stable = 0, m_bad = 0, m_refc = 0, m_fbc = 0, m_vprev = 0, m_lost = 0;
   bit m_ok = 0, m_prev_en = 0;
   bit [3:0] ref_h = '0, fb_h = '0;

   always @(posedge clk) begin : model
      int  v, incl, diff, dv;
      bit  rr, fr, stable, win, okf, loss;
      exp_t e;
      win = 1'b0;
      if (!reset) begin
         m_state = 0; m_stable = 0; m_bad = 0; m_refc = 0; m_fbc = 0;
         m_vprev = 0; m_lost = 0; m_ok = 0; m_prev_en = 0;
         ref_h = '0; fb_h = '0;
      end else begin
         // an input edge becomes visible to the counters three samples later
         rr = ref_h[2] & ~ref_h[3];
         fr = fb_h[2] & ~fb_h[3];
         ref_h = {ref_h[2:0], clk_ref};
         fb_h  = {fb_h[2:0], fb_clk};
         v  = filter_sign ? -int'(filter_out) : int'(filter_out);
         dv = v - m_vprev;
         if (dv < 0) dv = -dv;
         stable = m_prev_en && (dv <= TOL);
         m_vprev = v;
         m_prev_en = en;
         if (!en) begin
            m_state = 0; m_stable = 0; m_bad = 0; m_refc = 0; m_fbc = 0; m_ok = 0;
            if (clr_lost) m_lost = 0;
         end else begin
            incl = m_fbc + int'(fr);
            if (incl > FB_SAT) incl = FB_SAT;
            win  = rr && (m_refc == WIN - 1);
            diff = incl - WIN;
            okf  = (diff <= FREQ_TOL) && (diff >= -FREQ_TOL);
            loss = 1'b0;
            case (m_state)
               0: m_state = 1;
               1: if (m_stable == LOCK_CYCLES && (win ? okf : m_ok)) m_state = 2;
               default: if (m_bad == UNLOCK_CYCLES || (win && !okf)) begin
                  m_state = 1;
                  loss = 1'b1;
               end
            endcase
            if (loss) m_lost = 1;
            else if (clr_lost) m_lost = 0;
            if (loss || !stable) m_stable = 0;
            else if (m_stable < LOCK_CYCLES) m_stable++;
            if (stable) m_bad = 0;
            else if (m_bad < UNLOCK_CYCLES) m_bad++;
            if (win) begin
               fd_q.push_back(diff);
               m_ok = okf;
               m_refc = 0;
               m_fbc = 0;
            end else begin
               m_refc += int'(rr);
               m_fbc = incl;
            end
         end
      end
      e = {2'(m_state), (m_state == 2), 1'(m_lost), win};
      exp_q.push_back(e);
   end

   // Monitor: compare DUT outputs against queued expectations, away from the edge
   always @(posedge clk) begin : monitor
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs{ls,lock,lost,fv}", int'({lock_state, lock, lost_lock, freq_valid}), int'(e));
      end
      if (freq_valid) begin
         fv_seen++;
         last_fd = int'(freq_diff);
         if (fd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL freq_valid_unexpected actual=1 expected=0 at %0t", $time);
         end else begin
            check("freq_diff", int'(freq_diff), fd_q.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_filter(input int v);
      filter_sign = (v < 0);
      filter_out  = 5'((v < 0) ? -v : v);
   endtask

   task automatic set_neg_zero();
      filter_sign = 1'b1;
      filter_out  = 5'd0;
   endtask

   int ramp[$] = {5, 4, 3, 2, 1, 0, -100, 1, -100, 1, 2, 3, 4, 5};
   int rv;

   initial begin
      // Reset and idle with running clocks
      reset = 1'b0;
      cyc(4);
      check("reset_lock_state", int'(lock_state), 0);
      check("reset_freq_diff", int'(freq_diff), 0);
      reset = 1'b1;
      run_clk = 1'b1;
      cyc(60);
      check("idle_lock_state", int'(lock_state), 0);
      check("idle_no_freq_valid", fv_seen, 0);
      check("idle_lost_lock", int'(lost_lock), 0);

      // Clean lock
      en = 1'b1;
      set_filter(5);
      cyc(400);
      check("clean_lock", int'(lock), 1);
      check("clean_lock_state", int'(lock_state), 2);
      check("clean_freq_diff", last_fd, 0);
      check("clean_windows_seen", int'(fv_seen >= 2), 1);

      // Jitter within tolerance, including -0 <-> +1
      repeat (200) begin
         set_filter(5 + int'($urandom_range(0, 1)));
         cyc(1);
      end
      foreach (ramp[i]) begin
         if (ramp[i] == -100) set_neg_zero();
         else set_filter(ramp[i]);
         cyc(1);
      end
      check("jitter_lock", int'(lock), 1);

      // Phase unlock with a clear coinciding with the loss
      set_filter(-5);  cyc(1);
      set_filter(10);  cyc(1);
      set_filter(-10); cyc(1);
      set_filter(10);  cyc(1);
      clr_lost = 1'b1; cyc(1);
      clr_lost = 1'b0; cyc(2);
      check("phase_unlock_lock", int'(lock), 0);
      check("phase_unlock_state", int'(lock_state), 1);
      check("phase_unlock_lost_sticky", int'(lost_lock), 1);
      clr_lost = 1'b1; cyc(1);
      clr_lost = 1'b0; cyc(1);
      check("clr_lost_isolated", int'(lost_lock), 0);

      // Relock, then frequency unlock
      cyc(300);
      check("relock", int'(lock), 1);
      fb_per = 8;
      cyc(400);
      check("freq_unlock_diff", last_fd, 4);
      check("freq_unlock_lock", int'(lock), 0);
      check("freq_unlock_lost", int'(lost_lock), 1);
      fb_per = 10;
      cyc(450);
      check("relock_after_freq", int'(lock), 1);

      // Disable while locked
      en = 1'b0;
      cyc(1);
      check("disable_state", int'(lock_state), 0);
      check("disable_lost_holds", int'(lost_lock), 1);
      en = 1'b1;

      // Randomized run against the model
      rv = 10;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 5) rv = int'($urandom_range(0, 62)) - 31;
         else if ($urandom_range(0, 99) < 60) rv += int'($urandom_range(0, 2)) - 1;
         if (rv > 31) rv = 31;
         if (rv < -31) rv = -31;
         if (rv == 0 && $urandom_range(0, 1) == 1) set_neg_zero();
         else set_filter(rv);
         en = ($urandom_range(0, 999) >= 2);
         clr_lost = ($urandom_range(0, 99) < 2);
         if (i % 600 == 599) fb_per = 9 + int'($urandom_range(0, 2));
         if (i == 1500) reset = 1'b0;
         if (i == 1502) reset = 1'b1;
         cyc(1);
      end
      en = 1'b0;
      clr_lost = 1'b0;
      cyc(5);
      check("freq_queue_drained", fd_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adpll_lock_detector.md
Name: adpll_lock_detector

Overview:
- Lock monitor sitting beside the 5-bit ADPLL core; reads what the loop writes: sign-magnitude loop-filter output, plus the reference and feedback clocks.
- Declares lock when the filter output has settled and the feedback frequency matches the reference over a counting window.
- Declares loss of lock when either condition breaks, and keeps a sticky loss flag for firmware and debug pins.

Parameters:
- TOL, 1: max |filter change| between consecutive samples counted as "stable".
- LOCK_CYCLES, 64: consecutive stable samples required for lock.
- UNLOCK_CYCLES, 4: consecutive unstable samples that drop lock.
- WIN_LOG2, 4: frequency window is 2^WIN_LOG2 clk_ref rising edges.
- FREQ_TOL, 1: max |fb edges − ref edges| per window counted as "frequency ok".

Ports:
- clk  in  1  system clock; at least 4x the faster of clk_ref and fb_clk.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  detector enable; low forces IDLE and clears all counters.
- filter_out  in  5  loop-filter magnitude.
- filter_sign  in  1  loop-filter sign; 1 = negative.
- clk_ref  in  1  reference clock, asynchronous to clk.
- fb_clk  in  1  divided DCO feedback clock, asynchronous to clk.
- clr_lost  in  1  one-cycle pulse that clears lost_lock.
- lock  out  1  high while in LOCKED.
- lock_state  out  2  00 IDLE, 01 ACQ, 10 LOCKED; 11 is never driven.
- lost_lock  out  1  sticky; set on every LOCKED->ACQ transition.
- freq_diff  out  WIN_LOG2+2  signed (fb count − 2^WIN_LOG2) of the last completed window.
- freq_valid  out  1  one-cycle pulse when freq_diff updates.

Behaviour:
- Reset (reset=0): every output is 0, state is IDLE, all counters and the sample register are 0.
- Clock sync:
  - clk_ref and fb_clk each pass through a 2-flop synchronizer plus an edge flop.
  - A rising-edge pulse is produced 3 clk cycles after the input edge.
- Filter sampling:
  - Each clk, convert {filter_sign, filter_out} to a 6-bit two's-complement value v in −31..+31; −0 converts to 0.
  - delta = v − v_prev, computed in 7 bits, no overflow possible. v_prev is registered every cycle.
  - A sample is stable when |delta| <= TOL.
  - The first sample after leaving IDLE is not stable, because v_prev is invalid.
- Stability counters:
  - stable_cnt increments on a stable sample, saturates at LOCK_CYCLES, and clears on an unstable sample.
  - bad_cnt increments on an unstable sample, saturates at UNLOCK_CYCLES, and clears on a stable sample.
- Frequency window:
  - ref_cnt counts ref edges; fb_cnt counts fb edges and saturates at 2^(WIN_LOG2+1)−1.
  - On the ref edge that makes ref_cnt reach 2^WIN_LOG2, the next cycle does all of:
    - freq_diff <= fb_cnt_incl − 2^WIN_LOG2, where fb_cnt_incl includes an fb edge coincident with that ref edge;
    - freq_valid pulses;
    - freq_ok <= (|freq_diff| <= FREQ_TOL);
    - both counters restart at 0.
  - freq_ok resets to 0.
- FSM:
  - IDLE -> ACQ when en=1. Counters start that cycle.
  - ACQ -> LOCKED when stable_cnt == LOCK_CYCLES and freq_ok == 1 are both true in the same cycle.
  - LOCKED -> ACQ when bad_cnt reaches UNLOCK_CYCLES, or when a window completes with freq_ok=0. On this transition lost_lock <= 1 and stable_cnt is cleared.
  - Any state -> IDLE when en=0 (synchronous). freq_ok, stable_cnt, bad_cnt and the window counters clear. lost_lock holds.
- Outputs:
  - lock and lock_state are registered and follow the state with 0 extra latency (decoded from the state register).
- Simultaneous events:
  - clr_lost in the same cycle as a loss event: set wins, lost_lock = 1.
  - Window completion with freq_ok=0 in the same cycle as ACQ->LOCKED qualification: the fresh freq_ok is used, so the block stays in ACQ.
  - Asynchronous reset mid-window discards the partial window. No freq_valid is produced for it.

Decomposition:
- Package adpll_pkg:
  - lock_state encodings (LS_IDLE, LS_ACQ, LS_LOCKED);
  - sign-magnitude-to-two's-complement conversion function, shared with the other 5-bit loop blocks.
- Sub-module edge_sync_det: 2-flop synchronizer plus rising-edge pulse, instantiated twice (clk_ref, fb_clk).

Test Plan:
- Reset/idle: hold reset=0, then release with en=0 and toggle clocks -> all outputs 0, lock_state=00, no freq_valid.
- Clean lock: en=1, filter held at +5, fb_clk identical to clk_ref (period 10 clk) -> freq_valid every 160 clk with freq_diff=0; lock rises after both 64 stable samples and the first window (~165 clk); lock_state=10.
- Jitter within tolerance: while locked, alternate filter +5/+6 with TOL=1 -> lock stays 1. Sign-magnitude −0 to +1 counts as delta 1 -> stable.
- Phase unlock: while locked, filter steps +5 -> −5, then +10, −10, +10 (4 jumps) -> lock falls 1 cycle after the 4th unstable sample; lost_lock=1; lock_state=01.
- Frequency unlock: while locked, fb_clk period changes to 8 clk -> at the next window end freq_diff=+4 (20 fb edges vs 16 ref edges), freq_valid pulses, lock=0, lost_lock=1.
- Sticky and clear: issue a clr_lost pulse in the same cycle as a loss event -> lost_lock stays 1; a later isolated clr_lost pulse -> lost_lock=0. en=0 while locked -> lock_state=00 next cycle, lost_lock unchanged.
